// File: rtl/bus_dpram_pkg.sv
// Shared types and helpers for the DPRAM Port B arbiter slice.
// Pure declarations, no latency and no backpressure of its own.
package bus_dpram_pkg;

  localparam int BUS_WIDTH = 16;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } arb_state_t;

  // Index width that never collapses to zero bits, even for n = 1 or 2.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bus_dpram_portb_arbiter_if.sv
// Requester-side and RAM Port B signals of the arbiter, bundled as one port.
// Wires only, no latency; each requester holds i_Req until it sees its grant.
interface bus_dpram_portb_arbiter_if
  import bus_dpram_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int AW      = 8
);

  logic [NUM_REQ-1:0]           i_Req;
  logic [NUM_REQ-1:0]           i_Wr_Rd_n;
  logic [NUM_REQ*AW-1:0]        i_Addr16;
  logic [NUM_REQ*BUS_WIDTH-1:0] i_Wr_Data;
  logic [NUM_REQ-1:0]           o_Grant;
  logic [NUM_REQ-1:0]           o_Rd_DV;
  logic [BUS_WIDTH-1:0]         o_Rd_Data;
  logic [AW-1:0]                o_PortB_Addr16;
  logic [BUS_WIDTH-1:0]         o_PortB_Data;
  logic                         o_PortB_WE;
  logic [BUS_WIDTH-1:0]         i_PortB_Rd_Data;

  modport master (
    output i_Req, i_Wr_Rd_n, i_Addr16, i_Wr_Data, i_PortB_Rd_Data,
    input  o_Grant, o_Rd_DV, o_Rd_Data, o_PortB_Addr16, o_PortB_Data, o_PortB_WE
  );

  modport slave (
    input  i_Req, i_Wr_Rd_n, i_Addr16, i_Wr_Data, i_PortB_Rd_Data,
    output o_Grant, o_Rd_DV, o_Rd_Data, o_PortB_Addr16, o_PortB_Data, o_PortB_WE
  );

endinterface

// File: rtl/bus_dpram_portb_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, circularly.
// Zero latency; no backpressure, pick_vld is low when no request is set.
module rr_pick
  import bus_dpram_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int IW      = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic               pick_vld,
  output logic [IW-1:0]      pick_idx
);

  logic [IW-1:0] cand;

  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IW'((int'(ptr) + k) % NUM_REQ);
      if (!pick_vld && req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

endmodule

// File: rtl/bus_dpram_portb_arbiter.sv
// Round-robin owner of DPRAM Port B; grant one cycle after request, read DV one cycle after accept.
// A requester stalls by holding i_Req until granted; the owner is rotated after MAX_BURST accepts under contention.
module bus_dpram_portb_arbiter
  import bus_dpram_pkg::*;
#(
  parameter int DEPTH     = 256,
  parameter int NUM_REQ   = 2,
  parameter int MAX_BURST = 4
) (
  input logic                     i_Bus_Clk,
  input logic                     i_Bus_Rst,
  bus_dpram_portb_arbiter_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int IW = idx_w(NUM_REQ);
  localparam int CW = idx_w(MAX_BURST);

  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_REQ - 1);

  arb_state_t         state_q, state_n;
  logic [IW-1:0]      own_q, own_n;
  logic [IW-1:0]      rr_ptr_q, rr_ptr_n;
  logic [CW-1:0]      cnt_q, cnt_n;
  logic [NUM_REQ-1:0] grant_q;
  logic [NUM_REQ-1:0] rd_dv_q;

  logic [IW-1:0]      own_inc;
  logic [NUM_REQ-1:0] own_oh;
  logic [NUM_REQ-1:0] pick_req;
  logic [IW-1:0]      pick_ptr;
  logic [IW-1:0]      pick_idx;
  logic               pick_vld;
  logic               accept;
  logic               others_vld;

  logic [AW-1:0]        addr_a [NUM_REQ];
  logic [BUS_WIDTH-1:0] data_a [NUM_REQ];

  for (genvar n = 0; n < NUM_REQ; n++) begin : g_unpack
    assign addr_a[n] = bus.i_Addr16[n*AW +: AW];
    assign data_a[n] = bus.i_Wr_Data[n*BUS_WIDTH +: BUS_WIDTH];
  end

  assign own_oh     = NUM_REQ'(1) << own_q;
  assign own_inc    = (own_q == IDX_LAST) ? '0 : own_q + 1'b1;
  assign accept     = (state_q == ST_OWN) && bus.i_Req[own_q];
  assign others_vld = |(bus.i_Req & ~own_oh);

  // While owning, the single picker looks for the next requester after the owner.
  assign pick_req = (state_q == ST_OWN) ? (bus.i_Req & ~own_oh) : bus.i_Req;
  assign pick_ptr = (state_q == ST_OWN) ? own_inc : rr_ptr_q;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req      (pick_req),
    .ptr      (pick_ptr),
    .pick_vld (pick_vld),
    .pick_idx (pick_idx)
  );

  always_comb begin
    state_n  = state_q;
    own_n    = own_q;
    rr_ptr_n = rr_ptr_q;
    cnt_n    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          state_n = ST_OWN;
          own_n   = pick_idx;
          cnt_n   = '0;
        end
      end
      ST_OWN: begin
        if (!bus.i_Req[own_q]) begin
          rr_ptr_n = own_inc;
          cnt_n    = '0;
          if (pick_vld) begin
            own_n = pick_idx;
          end else begin
            state_n = ST_IDLE;
          end
        end else if (others_vld && (cnt_q == CNT_LAST)) begin
          own_n    = pick_idx;
          rr_ptr_n = own_inc;
          cnt_n    = '0;
        end else if (cnt_q != CNT_LAST) begin
          // Saturates at CNT_LAST so a lone owner never rotates away from itself.
          cnt_n = cnt_q + 1'b1;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Bus_Clk) begin
    if (i_Bus_Rst) begin
      state_q  <= ST_IDLE;
      own_q    <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      grant_q  <= '0;
      rd_dv_q  <= '0;
    end else begin
      state_q  <= state_n;
      own_q    <= own_n;
      rr_ptr_q <= rr_ptr_n;
      cnt_q    <= cnt_n;
      grant_q  <= (state_n == ST_OWN) ? (NUM_REQ'(1) << own_n) : '0;
      // Read target captured one-hot, so a grant change does not misroute the DV.
      rd_dv_q  <= (accept && !bus.i_Wr_Rd_n[own_q]) ? own_oh : '0;
    end
  end

  assign bus.o_Grant        = grant_q;
  assign bus.o_Rd_DV        = rd_dv_q;
  assign bus.o_Rd_Data      = bus.i_PortB_Rd_Data;
  assign bus.o_PortB_Addr16 = (state_q == ST_OWN) ? addr_a[own_q] : '0;
  assign bus.o_PortB_Data   = (state_q == ST_OWN) ? data_a[own_q] : '0;
  assign bus.o_PortB_WE     = accept && bus.i_Wr_Rd_n[own_q];

endmodule

// File: tb/tb_bus_dpram_portb_arbiter.sv
// Directed bench for the Port B arbiter with a behavioural registered-read RAM behind it.
// Inputs change and outputs are sampled just after the falling clock edge.
module tb_bus_dpram_portb_arbiter;

  localparam int NUM_REQ = 2;
  localparam int AW      = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        pa_we   = 1'b0;
  logic [7:0]  pa_addr = '0;
  logic [15:0] pa_data = '0;
  logic [15:0] mem [256];

  int n_cmp   = 0;
  int n_err   = 0;
  int dv_seen = 0;
  logic [1:0] exp_g;
  logic [1:0] exp_dv;

  always #5 clk = ~clk;

  bus_dpram_portb_arbiter_if #(.NUM_REQ(NUM_REQ), .AW(AW)) bus ();

  bus_dpram_portb_arbiter #(
    .DEPTH     (256),
    .NUM_REQ   (NUM_REQ),
    .MAX_BURST (4)
  ) dut (
    .i_Bus_Clk (clk),
    .i_Bus_Rst (rst),
    .bus       (bus)
  );

  // RAM: preload path plays the role of Port A; Port B has a one-cycle registered read.
  always @(posedge clk) begin
    if (pa_we) mem[pa_addr] <= pa_data;
    if (bus.o_PortB_WE) mem[bus.o_PortB_Addr16] <= bus.o_PortB_Data;
    bus.i_PortB_Rd_Data <= mem[bus.o_PortB_Addr16];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_Req     = '0;
    bus.i_Wr_Rd_n = '0;
    bus.i_Addr16  = '0;
    bus.i_Wr_Data = '0;

    // Reset, with 0xBEEF preloaded at 0x05.
    @(negedge clk); pa_we = 1'b1; pa_addr = 8'h05; pa_data = 16'hBEEF;
    @(negedge clk); pa_we = 1'b0;
    #1;
    chk("rst_grant", bus.o_Grant, 2'b00);
    chk("rst_dv",    bus.o_Rd_DV, 2'b00);
    chk("rst_we",    bus.o_PortB_WE, 1'b0);
    chk("rst_addr",  bus.o_PortB_Addr16, 8'h00);
    chk("rst_data",  bus.o_PortB_Data, 16'h0000);

    // Single read by requester 0.
    @(negedge clk); rst = 1'b0; bus.i_Req = 2'b01; bus.i_Wr_Rd_n = 2'b00; bus.i_Addr16 = {8'h00, 8'h05};
    #1; chk("t1_req_cycle_grant", bus.o_Grant, 2'b00);
    @(negedge clk); #1;
    chk("t1_grant", bus.o_Grant, 2'b01);
    chk("t1_we",    bus.o_PortB_WE, 1'b0);
    chk("t1_addr",  bus.o_PortB_Addr16, 8'h05);
    chk("t1_dv_early", bus.o_Rd_DV, 2'b00);
    @(negedge clk); bus.i_Req = 2'b00;
    #1;
    chk("t1_dv",    bus.o_Rd_DV, 2'b01);
    chk("t1_rdata", bus.o_Rd_Data, 16'hBEEF);
    chk("t1_rel_we", bus.o_PortB_WE, 1'b0);
    @(negedge clk); #1;
    chk("t1_idle_grant", bus.o_Grant, 2'b00);
    chk("t1_idle_dv",    bus.o_Rd_DV, 2'b00);

    // Requester 1 writes 0x1234 to 0x10, releases, reads it back.
    @(negedge clk); bus.i_Req = 2'b10; bus.i_Wr_Rd_n = 2'b10; bus.i_Addr16 = {8'h10, 8'h00};
    bus.i_Wr_Data = {16'h1234, 16'h0000};
    #1;
    chk("t2_req_grant", bus.o_Grant, 2'b00);
    chk("t2_req_we",    bus.o_PortB_WE, 1'b0);
    @(negedge clk); #1;
    chk("t2_grant", bus.o_Grant, 2'b10);
    chk("t2_we",    bus.o_PortB_WE, 1'b1);
    chk("t2_addr",  bus.o_PortB_Addr16, 8'h10);
    chk("t2_data",  bus.o_PortB_Data, 16'h1234);
    @(negedge clk); bus.i_Req = 2'b00;
    #1;
    chk("t2_rel_we", bus.o_PortB_WE, 1'b0);
    chk("t2_wr_nodv", bus.o_Rd_DV, 2'b00);
    @(negedge clk); bus.i_Req = 2'b10; bus.i_Wr_Rd_n = 2'b00;
    #1;
    chk("t2_rd_req_grant", bus.o_Grant, 2'b00);
    chk("t2_rd_req_we",    bus.o_PortB_WE, 1'b0);
    @(negedge clk); #1;
    chk("t2_rd_grant", bus.o_Grant, 2'b10);
    chk("t2_rd_we",    bus.o_PortB_WE, 1'b0);
    chk("t2_rd_addr",  bus.o_PortB_Addr16, 8'h10);
    @(negedge clk); bus.i_Req = 2'b00;
    #1;
    chk("t2_rd_dv",    bus.o_Rd_DV, 2'b10);
    chk("t2_rd_rdata", bus.o_Rd_Data, 16'h1234);
    @(negedge clk); #1;
    chk("t2_idle_grant", bus.o_Grant, 2'b00);

    // Contention: both read continuously, blocks of four accepts alternate.
    @(negedge clk); bus.i_Req = 2'b11; bus.i_Wr_Rd_n = 2'b00; bus.i_Addr16 = {8'h30, 8'h20};
    #1; chk("t3_req_grant", bus.o_Grant, 2'b00);
    exp_dv = 2'b00;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk); #1;
      exp_g = (((k - 1) / 4) % 2 == 0) ? 2'b01 : 2'b10;
      chk($sformatf("t3_grant_%0d", k), bus.o_Grant, exp_g);
      chk($sformatf("t3_dv_%0d", k),    bus.o_Rd_DV, exp_dv);
      exp_dv = exp_g;
    end
    @(negedge clk); bus.i_Req = 2'b00;
    #1;
    chk("t3_last_grant", bus.o_Grant, 2'b10);
    chk("t3_last_dv",    bus.o_Rd_DV, 2'b01);
    @(negedge clk); #1;
    chk("t3_idle_grant", bus.o_Grant, 2'b00);
    chk("t3_idle_dv",    bus.o_Rd_DV, 2'b00);

    // Uncontended burst of ten reads by requester 0.
    @(negedge clk); bus.i_Req = 2'b01; bus.i_Addr16 = {8'h00, 8'h05};
    #1; chk("t4_req_grant", bus.o_Grant, 2'b00);
    dv_seen = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk); #1;
      chk($sformatf("t4_grant_%0d", k), bus.o_Grant, 2'b01);
      if (bus.o_Rd_DV == 2'b01) dv_seen++;
    end
    @(negedge clk); bus.i_Req = 2'b00;
    #1;
    if (bus.o_Rd_DV == 2'b01) dv_seen++;
    chk("t4_dv_count", dv_seen, 10);
    chk("t4_rdata",    bus.o_Rd_Data, 16'hBEEF);
    @(negedge clk); #1;
    chk("t4_idle_grant", bus.o_Grant, 2'b00);

    // Reset during an accepted read by requester 1.
    @(negedge clk); bus.i_Req = 2'b10; bus.i_Addr16 = {8'h10, 8'h05};
    #1; chk("t6_req_grant", bus.o_Grant, 2'b00);
    @(negedge clk); rst = 1'b1;
    #1; chk("t6_acc_grant", bus.o_Grant, 2'b10);
    @(negedge clk); rst = 1'b0; bus.i_Req = 2'b11;
    #1;
    chk("t6_post_grant", bus.o_Grant, 2'b00);
    chk("t6_post_dv",    bus.o_Rd_DV, 2'b00);
    chk("t6_post_we",    bus.o_PortB_WE, 1'b0);

    // Release fairness, both requesting straight after reset.
    @(negedge clk); #1;
    chk("t5_first_grant", bus.o_Grant, 2'b01);
    @(negedge clk); #1;
    chk("t5_second_grant", bus.o_Grant, 2'b01);
    @(negedge clk); bus.i_Req = 2'b10;
    #1;
    chk("t5_rel_grant", bus.o_Grant, 2'b01);
    chk("t5_rel_we",    bus.o_PortB_WE, 1'b0);
    chk("t5_rel_dv",    bus.o_Rd_DV, 2'b01);
    @(negedge clk); bus.i_Req = 2'b11;
    #1;
    chk("t5_new_owner", bus.o_Grant, 2'b10);
    chk("t5_new_dv",    bus.o_Rd_DV, 2'b00);
    for (int k = 5; k <= 7; k++) begin
      @(negedge clk); #1;
      chk($sformatf("t5_hold_grant_%0d", k), bus.o_Grant, 2'b10);
      chk($sformatf("t5_hold_dv_%0d", k),    bus.o_Rd_DV, 2'b10);
    end
    @(negedge clk); #1;
    chk("t5_back_grant", bus.o_Grant, 2'b01);
    chk("t5_back_dv",    bus.o_Rd_DV, 2'b10);
    @(negedge clk); bus.i_Req = 2'b00;
    #1;
    chk("t5_end_dv", bus.o_Rd_DV, 2'b01);
    @(negedge clk); #1;
    chk("t5_idle_grant", bus.o_Grant, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
